bin_to_bcd6: RTL

BIN_TO_BCD6 -- requirements
Module: bin_to_bcd6

---
 rtl/bin_to_bcd6.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/bin_to_bcd6.sv
//==============================================================================
// Module      : bin_to_bcd6
// Description : Sequential double-dabble converter from a 20-bit binary value
//               to six registered BCD digits. Saturates above 999999 and can
//               optionally blank leading zeros for seven-segment display.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module bin_to_bcd6 #(
  parameter bit BLANK_LZ = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [19:0] bin_in,
  output logic       busy,
  output logic       done,
  output logic       overflow,
  output logic [3:0] bcd_HEX0,
  output logic [3:0] bcd_HEX1,
  output logic [3:0] bcd_HEX2,
  output logic [3:0] bcd_HEX3,
  output logic [3:0] bcd_HEX4,
  output logic [3:0] bcd_HEX5
);

  localparam logic [0:0]  S_IDLE      = 1'b0;
  localparam logic [0:0]  S_CONV      = 1'b1;
  localparam logic [4:0]  c_LAST_ITER = 5'd19;
  localparam logic [19:0] c_MAX_DEC   = 20'd999999;
  localparam logic [3:0]  c_BLANK     = 4'hF;
  localparam logic [3:0]  c_NINE      = 4'd9;
  localparam logic [3:0]  c_RST_UPPER = BLANK_LZ ? 4'hF : 4'h0;

  logic [0:0]  r_state;
  logic [0:0]  w_state_nxt;
  logic        w_accept;
  logic        w_last;
  logic        w_busy;

  logic [19:0] r_shift;
  logic [23:0] r_scratch;
  logic [4:0]  r_cnt;
  logic        r_ovf_pend;

  logic [23:0] w_adj;
  logic [23:0] w_scratch_nxt;
  logic [19:0] w_shift_nxt;
  logic [23:0] w_final;

  logic        r_done;
  logic        r_ovf;
  logic [23:0] r_dig;

  //--------------------------------------------------------------------------
  // FSM: state register
  //--------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  //--------------------------------------------------------------------------
  // FSM: next-state logic
  //--------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_CONV;
        end
      end
      S_CONV: begin
        if (r_cnt == c_LAST_ITER) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  //--------------------------------------------------------------------------
  // FSM: output logic
  //--------------------------------------------------------------------------
  always_comb begin
    w_busy   = 1'b0;
    w_accept = 1'b0;
    w_last   = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_accept = start;
      end
      S_CONV: begin
        w_busy = 1'b1;
        w_last = (r_cnt == c_LAST_ITER);
      end
      default: begin
        w_busy = 1'b0;
      end
    endcase
  end

  //--------------------------------------------------------------------------
  // Double-dabble step: add 3 to every nibble >= 5, then shift left by one
  //--------------------------------------------------------------------------
  for (genvar gi = 0; gi < 6; gi++) begin : g_add3
    assign w_adj[gi*4 +: 4] = (r_scratch[gi*4 +: 4] >= 4'd5)
                              ? (r_scratch[gi*4 +: 4] + 4'd3)
                              : r_scratch[gi*4 +: 4];
  end

  assign w_scratch_nxt = {w_adj[22:0], r_shift[19]};
  assign w_shift_nxt   = {r_shift[18:0], 1'b0};

  //--------------------------------------------------------------------------
  // Final digit shaping: saturation wins over leading-zero blanking
  //--------------------------------------------------------------------------
  assign w_final[3:0] = r_ovf_pend ? c_NINE : w_scratch_nxt[3:0];

  for (genvar gd = 1; gd < 6; gd++) begin : g_blank
    logic w_lead_zero;
    assign w_lead_zero = ~|w_scratch_nxt[23:gd*4];
    assign w_final[gd*4 +: 4] = r_ovf_pend                  ? c_NINE  :
                                (BLANK_LZ && w_lead_zero)   ? c_BLANK :
                                w_scratch_nxt[gd*4 +: 4];
  end

  //--------------------------------------------------------------------------
  // Conversion datapath
  //--------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift    <= '0;
      r_scratch  <= '0;
      r_cnt      <= '0;
      r_ovf_pend <= 1'b0;
    end else if (w_accept) begin
      r_shift    <= bin_in;
      r_scratch  <= '0;
      r_cnt      <= '0;
      r_ovf_pend <= (bin_in > c_MAX_DEC);
    end else if (w_busy) begin
      r_shift    <= w_shift_nxt;
      r_scratch  <= w_scratch_nxt;
      r_cnt      <= r_cnt + 5'd1;
    end
  end

  // Results only update on the final iteration, so partial sums never leak out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_done <= 1'b0;
      r_ovf  <= 1'b0;
      r_dig  <= {{5{c_RST_UPPER}}, 4'h0};
    end else begin
      r_done <= w_last;
      if (w_last) begin
        r_dig <= w_final;
        r_ovf <= r_ovf_pend;
      end
    end
  end

  assign busy     = w_busy;
  assign done     = r_done;
  assign overflow = r_ovf;
  assign bcd_HEX0 = r_dig[3:0];
  assign bcd_HEX1 = r_dig[7:4];
  assign bcd_HEX2 = r_dig[11:8];
  assign bcd_HEX3 = r_dig[15:12];
  assign bcd_HEX4 = r_dig[19:16];
  assign bcd_HEX5 = r_dig[23:20];

endmodule

`default_nettype wire
